data_mem_responder: RTL and testbench

//   Responder end of the MEM-stage data-memory interface: accepts one read or write request from the

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, FSM states and lane helpers for the data-memory responder
package mem_pkg;

  typedef enum logic [1:0] {
    BS_WORD = 2'b00,
    BS_HALF = 2'b01,
    BS_BYTE = 2'b10,
    BS_RSVD = 2'b11
  } byte_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] LANES_WORD = 4'b1111;
  localparam logic [3:0] LANES_HI_HALF = 4'b1100;
  localparam logic [3:0] LANES_LO_HALF = 4'b0011;
  localparam logic [3:0] LANES_BYTE0 = 4'b1000;

  // Bit k enables bits [8k+7:8k]; big-endian, so offset 0 maps to lane 3.
  function automatic logic [3:0] lane_enables(input logic [1:0] sel, input logic [1:0] off);
    case (sel)
      BS_HALF: lane_enables = off[1] ? LANES_LO_HALF : LANES_HI_HALF;
      BS_BYTE: lane_enables = LANES_BYTE0 >> off;
      default: lane_enables = LANES_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian write merge and read extract/extend for one 32-bit word
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_byte_sel,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_load_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_word,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [3:0]  w_be;
  logic [31:0] w_rep;
  logic [31:0] w_mask;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_be   = lane_enables(i_byte_sel, i_addr_lo);
    w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    case (i_byte_sel)
      BS_HALF: w_rep = {2{i_wdata[15:0]}};
      BS_BYTE: w_rep = {4{i_wdata[7:0]}};
      default: w_rep = i_wdata;
    endcase
    o_merged = (w_rep & w_mask) | (i_mem_word & ~w_mask);

    w_half = i_addr_lo[1] ? i_mem_word[15:0] : i_mem_word[31:16];
    case (i_addr_lo)
      2'd0:    w_byte = i_mem_word[31:24];
      2'd1:    w_byte = i_mem_word[23:16];
      2'd2:    w_byte = i_mem_word[15:8];
      default: w_byte = i_mem_word[7:0];
    endcase

    case (i_byte_sel)
      BS_HALF: begin
        o_rdata      = {{16{i_load_signed & w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      BS_BYTE: begin
        o_rdata      = {{24{i_load_signed & w_byte[7]}}, w_byte};
        o_misaligned = 1'b0;
      end
      default: begin
        o_rdata      = i_mem_word;
        o_misaligned = (i_addr_lo != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data RAM responder: accept, wait, one-cycle Ready pulse
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ByteSel,
  input  logic        LoadSigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        AddrError
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      r_state;
  state_e      w_next;
  logic [3:0]  r_cnt;
  logic        r_rd, r_wr, r_signed;
  logic [1:0]  r_sel;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_rdata;
  logic        r_ready, r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req, w_accept, w_enter_resp, w_commit;
  logic        w_rd, w_wr, w_signed, w_err, w_range_err, w_misaligned;
  logic [1:0]  w_sel;
  logic [31:0] w_addr, w_wdata, w_word, w_merged, w_rdata;
  logic [AW-1:0] w_idx;

  assign w_req = MemRead | MemWrite;

  // In IDLE the live request is used so a zero-wait build can respond on the accept edge.
  assign w_rd     = (r_state == ST_IDLE) ? MemRead    : r_rd;
  assign w_wr     = (r_state == ST_IDLE) ? MemWrite   : r_wr;
  assign w_sel    = (r_state == ST_IDLE) ? ByteSel    : r_sel;
  assign w_signed = (r_state == ST_IDLE) ? LoadSigned : r_signed;
  assign w_addr   = (r_state == ST_IDLE) ? Address    : r_addr;
  assign w_wdata  = (r_state == ST_IDLE) ? WriteData  : r_wdata;

  assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_err       = w_range_err | w_misaligned;
  assign w_idx       = w_addr[AW+1:2];
  assign w_word      = w_range_err ? 32'd0 : r_mem[w_idx];

  mem_lane_align u_align (
    .i_byte_sel    (w_sel),
    .i_addr_lo     (w_addr[1:0]),
    .i_load_signed (w_signed),
    .i_wdata       (w_wdata),
    .i_mem_word    (w_word),
    .o_merged      (w_merged),
    .o_rdata       (w_rdata),
    .o_misaligned  (w_misaligned)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: if (w_req) begin
        w_accept = 1'b1;
        w_next   = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign Stall        = ((r_state == ST_IDLE) & w_req) | (r_state == ST_WAIT);
  assign w_enter_resp = (w_next == ST_RESP) & (r_state != ST_RESP);
  assign w_commit     = w_enter_resp & w_wr & ~w_err;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_sel    <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt    <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
        r_rd     <= MemRead;
        r_wr     <= MemWrite;
        r_sel    <= ByteSel;
        r_signed <= LoadSigned;
        r_addr   <= Address;
        r_wdata  <= WriteData;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp & w_err;
      r_rdata <= (w_enter_resp & w_rd & ~w_wr & ~w_err) ? w_rdata : 32'd0;
    end
  end

  always_ff @(posedge Clock) begin
    if (w_commit) r_mem[w_idx] <= w_merged;
  end

  assign ReadData  = r_rdata;
  assign Ready     = r_ready;
  assign AddrError = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, sg, rd0, wr0, sg0;
  logic [1:0]  bs, bs0;
  logic [31:0] addr, wd, addr0, wd0;
  logic [31:0] rdata, rdata0;
  logic        ready, stall, aerr, ready0, stall0, aerr0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
    .Clock(clk), .Reset(rst_n), .MemRead(rd), .MemWrite(wr), .ByteSel(bs),
    .LoadSigned(sg), .Address(addr), .WriteData(wd), .ReadData(rdata),
    .Ready(ready), .Stall(stall), .AddrError(aerr)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .Clock(clk), .Reset(rst_n), .MemRead(rd0), .MemWrite(wr0), .ByteSel(bs0),
    .LoadSigned(sg0), .Address(addr0), .WriteData(wd0), .ReadData(rdata0),
    .Ready(ready0), .Stall(stall0), .AddrError(aerr0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit z, input logic r, input logic w, input logic [1:0] b,
                       input logic s, input logic [31:0] a, input logic [31:0] d);
    if (!z) begin rd = r; wr = w; bs = b; sg = s; addr = a; wd = d; end
    else begin rd0 = r; wr0 = w; bs0 = b; sg0 = s; addr0 = a; wd0 = d; end
  endtask

  // z selects the zero-wait instance. lat counts cycles from the accept cycle to Ready.
  task automatic req(input bit z, input logic r, input logic w, input logic [1:0] b,
                     input logic s, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdat, output logic err, output int lat,
                     output int stl, output logic [32:0] post);
    @(negedge clk);
    drive(z, r, w, b, s, a, d);
    lat = -1; stl = 0; rdat = '0; err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (z ? stall0 : stall) stl++;
      if (z ? ready0 : ready) begin
        lat = c; rdat = z ? rdata0 : rdata; err = z ? aerr0 : aerr;
        break;
      end
    end
    drive(z, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    check("ready_seen", 32'(lat >= 0), 32'd1);
    @(negedge clk); #1;
    post = z ? {ready0, rdata0} : {ready, rdata};
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, stl;
  logic [32:0] post;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_aerr", 32'(aerr), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    req(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, d, e, lat, stl, post);
    check("w_lat", 32'(lat), 32'd2);
    check("w_stall", 32'(stl), 32'd2);
    check("w_err", 32'(e), 32'd0);
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, d, e, lat, stl, post);
    check("r_data", d, 32'hDEADBEEF);
    check("r_lat", 32'(lat), 32'd2);
    check("r_stall", 32'(stl), 32'd2);
    check("r_post", 32'(post[32]), 32'd0);
    check("r_post_data", post[31:0], 32'd0);

    req(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h55, d, e, lat, stl, post);
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, d, e, lat, stl, post);
    check("bw_word", d, 32'hDE55BEEF);
    req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'd0, d, e, lat, stl, post);
    check("br_u11", d, 32'h00000055);
    req(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, d, e, lat, stl, post);
    check("hr_s10", d, 32'hFFFFDE55);
    req(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'd0, d, e, lat, stl, post);
    check("br_s13", d, 32'hFFFFFFEF);
    req(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, d, e, lat, stl, post);
    check("hr_u12", d, 32'h0000BEEF);

    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'd0, d, e, lat, stl, post);
    check("mis_word_err", 32'(e), 32'd1);
    check("mis_word_data", d, 32'd0);
    req(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'hAAAA, d, e, lat, stl, post);
    check("mis_half_err", 32'(e), 32'd1);
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, d, e, lat, stl, post);
    check("mis_half_nowr", d, 32'hDE55BEEF);
    req(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, d, e, lat, stl, post);
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, d, e, lat, stl, post);
    check("hw_word", d, 32'hDE551234);

    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'd0, d, e, lat, stl, post);
    check("oor_err", 32'(e), 32'd1);
    check("oor_data", d, 32'd0);
    req(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'hFFC, 32'hCAFEF00D, d, e, lat, stl, post);
    check("last_w_err", 32'(e), 32'd0);
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFC, 32'd0, d, e, lat, stl, post);
    check("last_r", d, 32'hCAFEF00D);
    req(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h1, d, e, lat, stl, post);
    check("rw_data", d, 32'd0);
    check("rw_err", 32'(e), 32'd0);
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'd0, d, e, lat, stl, post);
    check("rw_written", d, 32'h1);

    req(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h0BADF00D, d, e, lat, stl, post);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h12345678);
    @(negedge clk); #1;
    check("abort_in_wait", 32'(stall), 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'd0, d, e, lat, stl, post);
    check("abort_nowr", d, 32'h0BADF00D);

    req(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h11223344, d, e, lat, stl, post);
    check("z_w_lat", 32'(lat), 32'd1);
    check("z_w_stall", 32'(stl), 32'd1);
    req(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'd0, d, e, lat, stl, post);
    check("z_r_data", d, 32'h11223344);
    check("z_r_lat", 32'(lat), 32'd1);
    check("z_r_post", 32'(post[32]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
